// File: rtl/div_pkg.sv
// Shared encodings and helpers for the multi-cycle divider.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam int   DoubleRegBus      = 64;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div.sv
// Restoring radix-2 divider, one quotient bit per cycle.
// Result packs {remainder, quotient} for the HI/LO pair.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [31:0]             opdata1_i,
  input  logic [31:0]             opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_t  state;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] diff;
  logic [31:0] quot;
  logic [31:0] rem;

  assign op1_abs = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;

  // Bit 32 set means the trial subtraction borrowed: keep the old remainder.
  assign diff = {1'b0, work[63:32]} - {1'b0, divisor};

  assign quot = neg_q ? neg32(work[31:0])  : work[31:0];
  assign rem  = neg_r ? neg32(work[64:33]) : work[64:33];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= '0;
      work     <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      unique case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= DivByZero;
            end else begin
              state   <= DivOn;
              cnt     <= '0;
              work    <= {32'd0, op1_abs, 1'b0};
              divisor <= op2_abs;
              neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_r   <= signed_div_i & opdata1_i[31];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else begin
            state    <= DivEnd;
            work     <= '0;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt != 6'd32) begin
            if (diff[32]) begin
              work <= {work[63:0], 1'b0};
            end else begin
              work <= {diff[31:0], work[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            state    <= DivEnd;
            cnt      <= '0;
            result_o <= {rem, quot};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
      endcase
    end
  end

endmodule
